// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the coherent memory arbiter.
//   word_t      : 32-bit data/address word
//   ramstate_t  : handshake state reported by the RAM model/controller
//   arb_state_t : arbiter FSM state
// SNOOP and WB only have behaviour when MEM_ARB_COHERENCE_EN is defined.
// ---------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SNOOP  = 3'd1,
    WB     = 3'd2,
    MEM    = 3'd3,
    IFETCH = 3'd4
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector. The search starts at last+1 (mod N)
// and wraps, so the most recently served requester has lowest priority.
// Ports:
//   req   [N]  : request vector
//   last  [IW] : index of the previous completed grant
//   valid      : at least one request present
//   idx   [IW] : selected requester (0 when valid is low)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Walk from farthest to nearest so the nearest requester after 'last'
  // is the final assignment and therefore wins.
  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = N; i >= 1; i--) begin
      j = (int'(last) + i) % N;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/coherent_mem_arbiter.sv
// ---------------------------------------------------------------------------
// coherent_mem_arbiter
// Arbitrates CPUS cores' instruction and data ports onto one RAM port, with
// optional snoop-based coherence (define MEM_ARB_COHERENCE_EN). Data
// requests always beat instruction requests; each class has its own
// round-robin pointer that only moves when a transaction completes.
// Ports:
//   CLK, RST              : clock, synchronous active-high reset
//   iREN/iaddr/iwait      : per-core instruction read port
//   dREN/dWEN/daddr/dstore/dwait : per-core data port
//   ccwrite/cctrans       : coherence inputs (intent / dirty, snoop hit)
//   ccwait/ccinv/ccsnoopaddr : snoop stall, invalidate, snoop address
//   load                  : broadcast load data
//   ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate : RAM port
// Without MEM_ARB_COHERENCE_EN, reads go straight to MEM and all cc outputs
// are tied low.
// ---------------------------------------------------------------------------
module coherent_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*ADDR_W-1:0] iaddr,
  output logic [CPUS-1:0]        iwait,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*ADDR_W-1:0] daddr,
  input  logic [CPUS*ADDR_W-1:0] dstore,
  output logic [CPUS-1:0]        dwait,
  input  logic [CPUS-1:0]        ccwrite,
  input  logic [CPUS-1:0]        cctrans,
  output logic [CPUS-1:0]        ccwait,
  output logic [CPUS-1:0]        ccinv,
  output logic [ADDR_W-1:0]      ccsnoopaddr,
  output logic [ADDR_W-1:0]      load,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [ADDR_W-1:0]      ramaddr,
  output logic [ADDR_W-1:0]      ramstore,
  input  logic [ADDR_W-1:0]      ramload,
  input  ramstate_t              ramstate
);

  localparam int IW = $clog2(CPUS);

  // Per-core views of the flattened buses
  logic [ADDR_W-1:0] iaddr_a  [CPUS];
  logic [ADDR_W-1:0] daddr_a  [CPUS];
  logic [ADDR_W-1:0] dstore_a [CPUS];

  for (genvar gi = 0; gi < CPUS; gi++) begin : g_unpack
    assign iaddr_a[gi]  = iaddr[gi*ADDR_W +: ADDR_W];
    assign daddr_a[gi]  = daddr[gi*ADDR_W +: ADDR_W];
    assign dstore_a[gi] = dstore[gi*ADDR_W +: ADDR_W];
  end

  arb_state_t    state_q, state_d;
  logic [IW-1:0] g_q, g_d;
  logic [IW-1:0] dptr_q, dptr_d;
  logic [IW-1:0] iptr_q, iptr_d;
  logic          wr_q, wr_d;     // granted data request is a write

  logic [CPUS-1:0] d_req;
  logic            d_gnt_v, i_gnt_v;
  logic [IW-1:0]   d_gnt, i_gnt;
  logic            g_live;       // granted request still asserted
  logic            done;         // completion in this cycle

  assign d_req = dREN | dWEN;

  rr_arbiter #(.N(CPUS)) u_rr_data (
    .req   (d_req),
    .last  (dptr_q),
    .valid (d_gnt_v),
    .idx   (d_gnt)
  );

  rr_arbiter #(.N(CPUS)) u_rr_inst (
    .req   (iREN),
    .last  (iptr_q),
    .valid (i_gnt_v),
    .idx   (i_gnt)
  );

  assign g_live = (state_q == IFETCH) ? iREN[g_q]
                : (wr_q ? dWEN[g_q] : dREN[g_q]);
  assign done   = g_live && (ramstate == ACCESS);

`ifdef MEM_ARB_COHERENCE_EN
  logic [IW-1:0] o_q, o_d;
  logic          hit_v;
  logic [IW-1:0] hit_idx;

  // Lowest-numbered other core holding the line dirty supplies the data
  always_comb begin
    hit_v   = 1'b0;
    hit_idx = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      if ((k != int'(g_q)) && cctrans[k] && ccwrite[k]) begin
        hit_v   = 1'b1;
        hit_idx = IW'(k);
      end
    end
  end
`else
  logic unused_cc;
  assign unused_cc = ^{ccwrite, cctrans};
`endif

  // Next-state logic. Losing the granted request before ACCESS abandons
  // the transaction without moving the round-robin pointer.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    dptr_d  = dptr_q;
    iptr_d  = iptr_q;
    wr_d    = wr_q;
`ifdef MEM_ARB_COHERENCE_EN
    o_d     = o_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_gnt_v) begin
          g_d  = d_gnt;
          wr_d = dWEN[d_gnt];
`ifdef MEM_ARB_COHERENCE_EN
          state_d = dWEN[d_gnt] ? MEM : SNOOP;
`else
          state_d = MEM;
`endif
        end else if (i_gnt_v) begin
          g_d     = i_gnt;
          wr_d    = 1'b0;
          state_d = IFETCH;
        end
      end
`ifdef MEM_ARB_COHERENCE_EN
      SNOOP: begin
        if (!g_live) begin
          state_d = IDLE;
        end else if (hit_v) begin
          o_d     = hit_idx;
          state_d = WB;
        end else begin
          state_d = MEM;
        end
      end
      WB: begin
        if (!g_live) begin
          state_d = IDLE;
        end else if (done) begin
          dptr_d  = g_q;
          state_d = IDLE;
        end
      end
`endif
      MEM: begin
        if (!g_live) begin
          state_d = IDLE;
        end else if (done) begin
          dptr_d  = g_q;
          state_d = IDLE;
        end
      end
      IFETCH: begin
        if (!g_live) begin
          state_d = IDLE;
        end else if (done) begin
          iptr_d  = g_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      g_q     <= '0;
      dptr_q  <= IW'(CPUS - 1);
      iptr_q  <= IW'(CPUS - 1);
      wr_q    <= 1'b0;
`ifdef MEM_ARB_COHERENCE_EN
      o_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      dptr_q  <= dptr_d;
      iptr_q  <= iptr_d;
      wr_q    <= wr_d;
`ifdef MEM_ARB_COHERENCE_EN
      o_q     <= o_d;
`endif
    end
  end

  // Outputs decode the registered state; waits drop combinationally in the
  // ACCESS cycle. RST forces the idle output pattern immediately.
  always_comb begin
    iwait       = '1;
    dwait       = '1;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    load        = ramload;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    if (!RST) begin
      case (state_q)
`ifdef MEM_ARB_COHERENCE_EN
        SNOOP: begin
          ccsnoopaddr = daddr_a[g_q];
          for (int k = 0; k < CPUS; k++) begin
            if (k != int'(g_q)) begin
              ccwait[k] = 1'b1;
              ccinv[k]  = ccwrite[g_q];
            end
          end
        end
        WB: begin
          ramWEN      = 1'b1;
          ramaddr     = daddr_a[g_q];
          ramstore    = dstore_a[o_q];
          load        = dstore_a[o_q];
          ccwait[o_q] = 1'b1;
          if (done) begin
            dwait[g_q] = 1'b0;
            dwait[o_q] = 1'b0;
          end
        end
`endif
        MEM: begin
          ramREN  = !wr_q;
          ramWEN  = wr_q;
          ramaddr = daddr_a[g_q];
          if (wr_q) ramstore = dstore_a[g_q];
          if (done) dwait[g_q] = 1'b0;
        end
        IFETCH: begin
          ramREN  = 1'b1;
          ramaddr = iaddr_a[g_q];
          if (done) iwait[g_q] = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coherent_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_coherent_mem_arbiter
// Directed scenarios plus a randomized run against a transaction-level
// model of the grant order (data before instruction, per-class round robin
// from the last completed grant). Coherence scenarios are compiled only
// when MEM_ARB_COHERENCE_EN is defined.
// ---------------------------------------------------------------------------
module tb_coherent_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 4;
  localparam int AW   = 32;

  logic             CLK = 1'b0;
  logic             RST;
  logic [CPUS-1:0]  iREN, dREN, dWEN, ccwrite, cctrans;
  logic [CPUS*AW-1:0] iaddr, daddr, dstore;
  logic [CPUS-1:0]  iwait, dwait, ccwait, ccinv;
  logic [AW-1:0]    ccsnoopaddr, load, ramaddr, ramstore, ramload;
  logic             ramREN, ramWEN;
  ramstate_t        ramstate;

  logic [AW-1:0] iaddr_a [CPUS];
  logic [AW-1:0] daddr_a [CPUS];
  logic [AW-1:0] dstore_a[CPUS];

  for (genvar gi = 0; gi < CPUS; gi++) begin : g_pack
    assign iaddr[gi*AW +: AW]  = iaddr_a[gi];
    assign daddr[gi*AW +: AW]  = daddr_a[gi];
    assign dstore[gi*AW +: AW] = dstore_a[gi];
  end

  int n_cmp = 0;
  int n_err = 0;

  // model state for the randomized run
  bit m_dpend[CPUS];
  bit m_dwr  [CPUS];
  bit m_ipend[CPUS];

  always #5 CLK = ~CLK;

  coherent_mem_arbiter #(.CPUS(CPUS), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait),
    .ccwrite(ccwrite), .cctrans(cctrans), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr), .load(load),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
    ramstate = FREE; ramload = '0;
    for (int i = 0; i < CPUS; i++) begin
      iaddr_a[i] = '0; daddr_a[i] = '0; dstore_a[i] = '0;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    RST = 1'b0;
  endtask

  function automatic ramstate_t rand_state();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return ACCESS;
    else if (r < 8) return BUSY;
    else return ERROR;
  endfunction

  // Wait (bounded) for any wait line to drop; returns at the negedge of the
  // completion cycle.
  task automatic wait_done(input int budget, input bit rand_ram,
                           output bit found, output bit is_i,
                           output int core, output int nlow);
    found = 1'b0; is_i = 1'b0; core = -1; nlow = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge CLK);
      nlow = $countones(~dwait) + $countones(~iwait);
      if (nlow != 0) begin
        found = 1'b1;
        for (int k = CPUS - 1; k >= 0; k--) begin
          if (!dwait[k]) begin core = k; is_i = 1'b0; end
        end
        if (core < 0) begin
          for (int k = CPUS - 1; k >= 0; k--) begin
            if (!iwait[k]) begin core = k; is_i = 1'b1; end
          end
        end
        break;
      end
      @(posedge CLK);
      #1;
      if (rand_ram) ramstate = rand_state();
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clear_inputs();
    dWEN = 4'b0001; iREN = 4'b0010; ramstate = ACCESS;
    next_cycle();
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (dwait !== 4'b1111 || iwait !== 4'b1111) begin
      n_err++;
      $display("FAIL reset_waits: dwait=%b iwait=%b required 1111/1111", dwait, iwait);
    end
    n_cmp++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ccwait !== 4'b0 || ccinv !== 4'b0) begin
      n_err++;
      $display("FAIL reset_strobes: ramREN=%b ramWEN=%b ccwait=%b ccinv=%b required 0", ramREN, ramWEN, ccwait, ccinv);
    end
    next_cycle();
    clear_inputs();
    RST = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_ifetch();
    clear_inputs();
    iREN[0] = 1'b1; iaddr_a[0] = 32'h100; ramload = 32'hCAFE_0100; ramstate = BUSY;
    @(negedge CLK);
    n_cmp++;
    if (iwait[0] !== 1'b1 || ramREN !== 1'b0) begin
      n_err++;
      $display("FAIL ifetch_c1: iwait0=%b ramREN=%b required 1/0", iwait[0], ramREN);
    end
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h100 || iwait[0] !== 1'b1) begin
      n_err++;
      $display("FAIL ifetch_c2: ramREN=%b ramaddr=%h iwait0=%b required 1/100/1", ramREN, ramaddr, iwait[0]);
    end
    next_cycle();
    next_cycle();
    ramstate = ACCESS;
    @(negedge CLK);
    n_cmp++;
    if (iwait !== 4'b1110 || load !== 32'hCAFE_0100) begin
      n_err++;
      $display("FAIL ifetch_c4: iwait=%b load=%h required 1110/cafe0100", iwait, load);
    end
    next_cycle();
    clear_inputs();
    @(negedge CLK);
    n_cmp++;
    if (ramREN !== 1'b0 || iwait !== 4'b1111) begin
      n_err++;
      $display("FAIL ifetch_after: ramREN=%b iwait=%b required 0/1111", ramREN, iwait);
    end
    $display("test_ifetch done");
  endtask

  task automatic test_dwrite();
    next_cycle();
    clear_inputs();
    dWEN[1] = 1'b1; daddr_a[1] = 32'h80; dstore_a[1] = 32'h1234; ramstate = ACCESS;
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h80 || ramstore !== 32'h1234) begin
      n_err++;
      $display("FAIL dwrite_strobe: ramWEN=%b ramREN=%b addr=%h store=%h required 1/0/80/1234", ramWEN, ramREN, ramaddr, ramstore);
    end
    n_cmp++;
    if (dwait !== 4'b1101 || ccwait !== 4'b0000) begin
      n_err++;
      $display("FAIL dwrite_wait: dwait=%b ccwait=%b required 1101/0000", dwait, ccwait);
    end
    next_cycle();
    clear_inputs();
    @(negedge CLK);
    n_cmp++;
    if (ramWEN !== 1'b0 || dwait !== 4'b1111) begin
      n_err++;
      $display("FAIL dwrite_after: ramWEN=%b dwait=%b required 0/1111", ramWEN, dwait);
    end
    $display("test_dwrite done");
  endtask

`ifndef MEM_ARB_COHERENCE_EN
  task automatic test_dread_direct();
    next_cycle();
    clear_inputs();
    dREN[0] = 1'b1; daddr_a[0] = 32'h44; ramload = 32'h5555_AAAA; ramstate = BUSY;
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h44 || ccwait !== 4'b0 || ccsnoopaddr !== 32'h0) begin
      n_err++;
      $display("FAIL dread_direct: ramREN=%b addr=%h ccwait=%b snoop=%h required 1/44/0000/0", ramREN, ramaddr, ccwait, ccsnoopaddr);
    end
    next_cycle();
    ramstate = ACCESS;
    @(negedge CLK);
    n_cmp++;
    if (dwait !== 4'b1110 || load !== 32'h5555_AAAA || ccwait !== 4'b0) begin
      n_err++;
      $display("FAIL dread_done: dwait=%b load=%h ccwait=%b required 1110/5555aaaa/0000", dwait, load, ccwait);
    end
    next_cycle();
    clear_inputs();
    $display("test_dread_direct done");
  endtask
`else
  task automatic test_snoop_wb();
    next_cycle();
    clear_inputs();
    dREN[0] = 1'b1; daddr_a[0] = 32'h40;
    cctrans[1] = 1'b1; ccwrite[1] = 1'b1; dstore_a[1] = 32'hDEAD; ramstate = BUSY;
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (ccsnoopaddr !== 32'h40 || ccwait !== 4'b1110 || ccinv !== 4'b0000 || dwait !== 4'b1111) begin
      n_err++;
      $display("FAIL snoop_phase: snoop=%h ccwait=%b ccinv=%b dwait=%b required 40/1110/0000/1111", ccsnoopaddr, ccwait, ccinv, dwait);
    end
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (ramWEN !== 1'b1 || ramaddr !== 32'h40 || ramstore !== 32'hDEAD || load !== 32'hDEAD || ccwait !== 4'b0010) begin
      n_err++;
      $display("FAIL wb_phase: ramWEN=%b addr=%h store=%h load=%h ccwait=%b required 1/40/dead/dead/0010", ramWEN, ramaddr, ramstore, load, ccwait);
    end
    next_cycle();
    ramstate = ACCESS;
    @(negedge CLK);
    n_cmp++;
    if (dwait !== 4'b1100) begin
      n_err++;
      $display("FAIL wb_done: dwait=%b required 1100", dwait);
    end
    next_cycle();
    clear_inputs();
    // reset while in WB abandons the write-back
    dREN[0] = 1'b1; daddr_a[0] = 32'h40;
    cctrans[1] = 1'b1; ccwrite[1] = 1'b1; dstore_a[1] = 32'hDEAD; ramstate = BUSY;
    next_cycle();
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (ramWEN !== 1'b1) begin
      n_err++;
      $display("FAIL wb_rst_pre: ramWEN=%b required 1", ramWEN);
    end
    next_cycle();
    RST = 1'b1;
    next_cycle();
    RST = 1'b0;
    clear_inputs();
    @(negedge CLK);
    n_cmp++;
    if (ramWEN !== 1'b0 || dwait !== 4'b1111 || iwait !== 4'b1111 || ccwait !== 4'b0) begin
      n_err++;
      $display("FAIL wb_rst_post: ramWEN=%b dwait=%b iwait=%b ccwait=%b required 0/1111/1111/0000", ramWEN, dwait, iwait, ccwait);
    end
    $display("test_snoop_wb done");
  endtask

  task automatic test_ccinv();
    next_cycle();
    clear_inputs();
    dREN[1] = 1'b1; ccwrite[1] = 1'b1; daddr_a[1] = 32'h88; ramstate = BUSY;
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (ccinv !== 4'b1101 || ccwait !== 4'b1101) begin
      n_err++;
      $display("FAIL ccinv: ccinv=%b ccwait=%b required 1101/1101", ccinv, ccwait);
    end
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h88) begin
      n_err++;
      $display("FAIL snoop_miss_mem: ramREN=%b ramWEN=%b addr=%h required 1/0/88", ramREN, ramWEN, ramaddr);
    end
    next_cycle();
    clear_inputs();
    next_cycle();
    $display("test_ccinv done");
  endtask
`endif

  task automatic test_round_robin();
    bit found, is_i;
    int core, nlow;
    do_reset();
    for (int i = 0; i < CPUS; i++) daddr_a[i] = 32'h1000 + 32'(i * 4);
    dREN = 4'b1111; iREN[2] = 1'b1; iaddr_a[2] = 32'h2000; ramstate = ACCESS;
    for (int n = 0; n < 5; n++) begin
      wait_done(40, 1'b0, found, is_i, core, nlow);
      n_cmp++;
      if (!found || is_i || core != (n % CPUS)) begin
        n_err++;
        $display("FAIL rr_grant%0d: found=%0d instr=%0d core=%0d required data core %0d", n, found, is_i, core, n % CPUS);
      end
      next_cycle();
    end
    dREN = '0;
    wait_done(40, 1'b0, found, is_i, core, nlow);
    n_cmp++;
    if (!found || !is_i || core != 2) begin
      n_err++;
      $display("FAIL rr_ifetch_after: found=%0d instr=%0d core=%0d required instr core 2", found, is_i, core);
    end
    next_cycle();
    clear_inputs();
    $display("test_round_robin done");
  endtask

  task automatic test_abort();
    bit found, is_i;
    int core, nlow;
    // data pointer sits at core 0 after the round-robin test
    dWEN[3] = 1'b1; daddr_a[3] = 32'h300; dstore_a[3] = 32'h33; ramstate = BUSY;
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (ramWEN !== 1'b1 || ramaddr !== 32'h300) begin
      n_err++;
      $display("FAIL abort_pre: ramWEN=%b addr=%h required 1/300", ramWEN, ramaddr);
    end
    next_cycle();
    dWEN[3] = 1'b0;
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (ramWEN !== 1'b0 || ramREN !== 1'b0 || dwait !== 4'b1111) begin
      n_err++;
      $display("FAIL abort_post: ramWEN=%b ramREN=%b dwait=%b required 0/0/1111", ramWEN, ramREN, dwait);
    end
    next_cycle();
    dWEN[0] = 1'b1; dWEN[3] = 1'b1; ramstate = ACCESS;
    wait_done(40, 1'b0, found, is_i, core, nlow);
    n_cmp++;
    if (!found || is_i || core != 3) begin
      n_err++;
      $display("FAIL abort_ptr: found=%0d core=%0d required data core 3", found, core);
    end
    next_cycle();
    dWEN[3] = 1'b0;
    wait_done(40, 1'b0, found, is_i, core, nlow);
    n_cmp++;
    if (!found || is_i || core != 0) begin
      n_err++;
      $display("FAIL abort_next: found=%0d core=%0d required data core 0", found, core);
    end
    next_cycle();
    clear_inputs();
    $display("test_abort done");
  endtask

  task automatic apply_reqs();
    for (int i = 0; i < CPUS; i++) begin
      dREN[i] = m_dpend[i] && !m_dwr[i];
      dWEN[i] = m_dpend[i] && m_dwr[i];
      iREN[i] = m_ipend[i];
    end
  endtask

  task automatic raise_some();
    bit any;
    for (int i = 0; i < CPUS; i++) begin
      if (!m_dpend[i] && $urandom_range(0, 2) == 0) begin
        m_dpend[i] = 1'b1; m_dwr[i] = $urandom_range(0, 1) == 1;
        daddr_a[i] = $urandom; dstore_a[i] = $urandom;
      end
      if (!m_ipend[i] && $urandom_range(0, 3) == 0) begin
        m_ipend[i] = 1'b1; iaddr_a[i] = $urandom;
      end
    end
    any = 1'b0;
    for (int i = 0; i < CPUS; i++) any = any | m_dpend[i] | m_ipend[i];
    if (!any) begin
      m_ipend[0] = 1'b1; iaddr_a[0] = $urandom;
    end
    apply_reqs();
  endtask

  task automatic test_random();
    bit found, is_i, exp_i;
    int core, nlow, exp_core, mdp, mip, c;
    logic [AW-1:0] exp_addr;
    do_reset();
    mdp = CPUS - 1; mip = CPUS - 1;
    for (int i = 0; i < CPUS; i++) begin
      m_dpend[i] = 1'b0; m_dwr[i] = 1'b0; m_ipend[i] = 1'b0;
    end
    raise_some();
    ramstate = rand_state(); ramload = $urandom;
    for (int t = 0; t < 60; t++) begin
      // model: data class first, each class searched from last grant + 1
      exp_i = 1'b1; exp_core = -1;
      for (int s = 1; s <= CPUS; s++) begin
        c = (mdp + s) % CPUS;
        if (exp_core < 0 && m_dpend[c]) begin exp_core = c; exp_i = 1'b0; end
      end
      if (exp_core < 0) begin
        for (int s = 1; s <= CPUS; s++) begin
          c = (mip + s) % CPUS;
          if (exp_core < 0 && m_ipend[c]) exp_core = c;
        end
      end
      exp_addr = exp_i ? iaddr_a[exp_core] : daddr_a[exp_core];
      wait_done(200, 1'b1, found, is_i, core, nlow);
      n_cmp++;
      if (!found) begin
        n_err++;
        $display("FAIL rand_timeout tx%0d: no completion within 200 cycles", t);
        break;
      end
      n_cmp++;
      if (is_i !== exp_i || core != exp_core || nlow != 1) begin
        n_err++;
        $display("FAIL rand_grant tx%0d: instr=%0d core=%0d lows=%0d required instr=%0d core=%0d lows=1", t, is_i, core, nlow, exp_i, exp_core);
      end
      n_cmp++;
      if (ramaddr !== exp_addr) begin
        n_err++;
        $display("FAIL rand_addr tx%0d: ramaddr=%h required %h", t, ramaddr, exp_addr);
      end
      n_cmp++;
      if (!exp_i && m_dwr[exp_core]) begin
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== dstore_a[exp_core]) begin
          n_err++;
          $display("FAIL rand_write tx%0d: ramWEN=%b ramREN=%b store=%h required 1/0/%h", t, ramWEN, ramREN, ramstore, dstore_a[exp_core]);
        end
      end else begin
        if (ramREN !== 1'b1 || ramWEN !== 1'b0 || load !== ramload) begin
          n_err++;
          $display("FAIL rand_read tx%0d: ramREN=%b ramWEN=%b load=%h required 1/0/%h", t, ramREN, ramWEN, load, ramload);
        end
      end
      $display("rand tx%0d: %s core %0d addr %h", t, is_i ? "instr" : "data", core, ramaddr);
      // retire what the DUT actually served so stimulus stays consistent
      if (core >= 0) begin
        if (is_i) begin m_ipend[core] = 1'b0; mip = core; end
        else begin m_dpend[core] = 1'b0; mdp = core; end
      end
      next_cycle();
      raise_some();
      ramstate = rand_state(); ramload = $urandom;
    end
    next_cycle();
    clear_inputs();
    $display("test_random done");
  endtask

  task automatic test_reset_mid();
    bit found, is_i;
    int core, nlow;
    next_cycle();
    clear_inputs();
    dWEN[2] = 1'b1; daddr_a[2] = 32'h220; ramstate = BUSY;
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (ramWEN !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_pre: ramWEN=%b required 1", ramWEN);
    end
    next_cycle();
    RST = 1'b1;
    next_cycle();
    RST = 1'b0;
    clear_inputs();
    @(negedge CLK);
    n_cmp++;
    if (ramWEN !== 1'b0 || ramREN !== 1'b0 || dwait !== 4'b1111 || iwait !== 4'b1111) begin
      n_err++;
      $display("FAIL rstmid_post: ramWEN=%b ramREN=%b dwait=%b iwait=%b required 0/0/1111/1111", ramWEN, ramREN, dwait, iwait);
    end
    // pointers return to CPUS-1, so core 0 wins over core 1
    next_cycle();
    dWEN[0] = 1'b1; dWEN[1] = 1'b1; ramstate = ACCESS;
    wait_done(40, 1'b0, found, is_i, core, nlow);
    n_cmp++;
    if (!found || is_i || core != 0) begin
      n_err++;
      $display("FAIL rstmid_ptr: found=%0d core=%0d required data core 0", found, core);
    end
    next_cycle();
    clear_inputs();
    $display("test_reset_mid done");
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    test_reset();
    test_ifetch();
    test_dwrite();
`ifndef MEM_ARB_COHERENCE_EN
    test_dread_direct();
`else
    test_snoop_wb();
    test_ccinv();
`endif
    test_round_robin();
    test_abort();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/coherent_mem_arbiter.md
COHERENT_MEM_ARBITER -- requirements
Module: coherent_mem_arbiter

Interface
REQ-001 Parameter CPUS, default 2: number of cores; legal range 2..8.
REQ-002 Parameter ADDR_W, default 32: address and data word width.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  reset; synchronous, active-high.
REQ-005 iREN  in  CPUS  per-core instruction read request.
REQ-006 iaddr  in  CPUS*ADDR_W  per-core instruction address.
REQ-007 iwait  out  CPUS  per-core instruction wait; low only in the completion cycle.
REQ-008 dREN / dWEN  in  CPUS each  per-core data read / write request.
REQ-009 daddr / dstore  in  CPUS*ADDR_W each  per-core data address / store data.
REQ-010 dwait  out  CPUS  per-core data wait; low only in the completion cycle.
REQ-011 ccwrite  in  CPUS  requester: read-exclusive intent; snooped core: line dirty.
REQ-012 cctrans  in  CPUS  snooped core: snoop hit.
REQ-013 ccwait / ccinv  out  CPUS each  snoop stall / invalidate to each core.
REQ-014 ccsnoopaddr  out  ADDR_W  broadcast snoop address.
REQ-015 load  out  ADDR_W  broadcast load data to all cores.
REQ-016 ramREN / ramWEN  out  1 each  RAM read / write strobe.
REQ-017 ramaddr / ramstore  out  ADDR_W each  RAM address / write data.
REQ-018 ramload  in  ADDR_W; ramstate  in  ramstate_t (FREE, BUSY, ACCESS, ERROR).

Function
REQ-019 FSM states: IDLE, SNOOP, WB, MEM, IFETCH; grant index g and owner index o are registered.
REQ-020 IDLE: any dREN|dWEN wins over any iREN; a round-robin pointer per class starts search at last grant+1 mod CPUS.
REQ-021 A dWEN grant goes IDLE->MEM (write) with no snoop; a dREN grant goes IDLE->SNOOP; an iREN grant goes IDLE->IFETCH.
REQ-022 SNOOP lasts exactly 1 cycle: ccsnoopaddr=daddr[g], ccwait[k]=1 for all k!=g, ccinv[k]=ccwrite[g] for all k!=g.
REQ-023 SNOOP exit: lowest k!=g with cctrans[k]&ccwrite[k] becomes o, go to WB; otherwise go to MEM (read).
REQ-024 WB: ramWEN=1, ramaddr=daddr[g], ramstore=dstore[o], load=dstore[o], ccwait[o]=1; on ramstate==ACCESS, dwait[g]=0 and dwait[o]=0 in that cycle, then go to IDLE.
REQ-025 MEM/IFETCH: ramREN or ramWEN per request, ramaddr from granted port, load=ramload; the granted wait is 0 in the ACCESS cycle, then go to IDLE.
REQ-026 Stalls: BUSY and ERROR hold the state with strobes asserted (ERROR is retried); there is no timeout.
REQ-027 Abort: if the granted request drops before ACCESS, strobes deassert the next cycle and the FSM returns to IDLE without a pointer update.
REQ-028 Outside IDLE, all wait outputs of non-granted requesting ports are 1; waits of non-requesting ports are 1.
REQ-029 Round-robin pointers advance only on completion; simultaneous requests from all CPUS are each served within CPUS grants of their class.

Reset
REQ-030 While RST=1: state=IDLE, both pointers=CPUS-1, all wait/cc outputs 1/0 respectively (waits 1, ccwait/ccinv 0), ramREN=ramWEN=0; reset mid-transaction abandons it.

Configuration
REQ-031 With MEM_ARB_COHERENCE_EN defined: SNOOP and WB exist as specified.
REQ-032 Without MEM_ARB_COHERENCE_EN: dREN goes IDLE->MEM directly; ccwait, ccinv and ccsnoopaddr are tied to 0; SNOOP and WB are not generated.

Structure
REQ-033 cpu_types_pkg holds ramstate_t, word_t and the new arb_state_t enum.
REQ-034 One sub-module, rr_arbiter (parameter N), is instantiated twice: once for data and once for instruction.

Verification
REQ-035 CPUS=2, iREN[0] at 0x100, ramstate ACCESS after 2 BUSY: iwait[0]=0 in cycle 4, load=ramload.
REQ-036 dREN[0]@0x40, core1 cctrans=1 and ccwrite=1, dstore[1]=0xDEAD: SNOOP->WB, ramWEN at 0x40 with data 0xDEAD, load=0xDEAD, dwait[0]=dwait[1]=0 on ACCESS.
REQ-037 CPUS=4, all dREN held: grants in order 0,1,2,3,0; iREN[2] is held off until data requests clear.
REQ-038 dREN[1] with ccwrite[1]=1: ccinv=4'b1101 in SNOOP; no snoop hit leads to MEM read.
REQ-039 RST asserted in WB: next cycle ramWEN=0, state IDLE, all waits 1.
REQ-040 Build without MEM_ARB_COHERENCE_EN: dREN[0] reaches MEM in 1 cycle and ccwait stays 0.
